// File: rtl/seg7_display_mux.sv
// -----------------------------------------------------------------------------
// seg7_display_mux
//
// Purpose:
//   Time-multiplexes two 7-segment patterns (ones and tens) onto one shared
//   segment bus. Each digit owns a slot of REFRESH_DIV clock cycles, and two
//   slots make one frame. Every slot opens with DEAD_CYCLES cycles in which
//   both anodes are off, so the previous digit does not ghost. The input pair
//   is captured once per frame, at the start of the ones slot, so a frame
//   never mixes old and new values. When LZ_BLANK is set, a tens digit that
//   shows "0" is blanked. The blink input flashes the whole display: it is
//   visible for BLINK_FRAMES frames, then dark for BLINK_FRAMES frames.
//
// Ports:
//   clk         in   1  system clock
//   reset_n     in   1  asynchronous active-low reset
//   enable      in   1  1 = scan the display; 0 = dark, scan/blink counters cleared
//   blink       in   1  1 = flash the display
//   digit1      in   7  ones pattern, bit0=a .. bit6=g, 1 = segment lit
//   digit2      in   7  tens pattern, same encoding
//   seg         out  7  shared segment bus, polarity set by SEG_ACTIVE_LOW
//   an          out  2  digit anodes, active-low; an[0] = ones, an[1] = tens
//   frame_tick  out  1  one-cycle pulse after the last cycle of each frame
// -----------------------------------------------------------------------------
module seg7_display_mux #(
  parameter int REFRESH_DIV    = 1000,
  parameter int DEAD_CYCLES    = 2,
  parameter int BLINK_FRAMES   = 256,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int LZ_BLANK       = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       blink,
  input  logic [6:0] digit1,
  input  logic [6:0] digit2,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [6:0]    PAT_ZERO = 7'b0111111;

  logic [CW-1:0] r_cnt;
  logic          r_sel;
  logic [6:0]    r_shadow1;
  logic [6:0]    r_shadow2;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic [6:0]    r_seg;
  logic [1:0]    r_an;
  logic          r_frame_tick;

  logic          w_capture;
  logic          w_cnt_wrap;
  logic          w_frame_end;
  logic          w_dead;
  logic          w_blank;
  logic [6:0]    w_pat1;
  logic [6:0]    w_pat2;
  logic [6:0]    w_pat;
  logic [1:0]    w_an_next;
  logic [6:0]    w_seg_next;

  assign w_capture   = (r_cnt == '0) && !r_sel;
  assign w_cnt_wrap  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_cnt_wrap && r_sel;

  // The leading dead window only exists when DEAD_CYCLES is non-zero;
  // splitting it out avoids a constant-false unsigned compare.
  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign w_dead = 1'b0;
    end else begin : g_dead
      localparam logic [CW-1:0] DEAD_LIM = CW'(DEAD_CYCLES);
      assign w_dead = (r_cnt < DEAD_LIM);
    end
  endgenerate

  // On the capture edge the decode already sees the incoming pair, so the
  // whole frame (including its first cycle when DEAD_CYCLES is 0) shows one
  // coherent pair.
  assign w_pat1 = w_capture ? digit1 : r_shadow1;
  assign w_pat2 = w_capture ? digit2 : r_shadow2;
  assign w_pat  = r_sel ? w_pat2 : w_pat1;

  assign w_blank = (blink && r_phase) ||
                   ((LZ_BLANK != 0) && r_sel && (w_pat2 == PAT_ZERO));

  always_comb begin
    w_an_next  = 2'b11;
    w_seg_next = SEG_OFF;
    if (!w_dead && !w_blank) begin
      w_an_next  = r_sel ? 2'b01 : 2'b10;
      w_seg_next = (SEG_ACTIVE_LOW != 0) ? ~w_pat : w_pat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_sel        <= 1'b0;
      r_shadow1    <= '0;
      r_shadow2    <= '0;
      r_blink_cnt  <= '0;
      r_phase      <= 1'b0;
      r_seg        <= SEG_OFF;
      r_an         <= 2'b11;
      r_frame_tick <= 1'b0;
    end else if (!enable) begin
      // Shadows hold; everything else returns to the start of a frame.
      r_cnt        <= '0;
      r_sel        <= 1'b0;
      r_blink_cnt  <= '0;
      r_phase      <= 1'b0;
      r_seg        <= SEG_OFF;
      r_an         <= 2'b11;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
      if (w_cnt_wrap) begin
        r_sel <= ~r_sel;
      end

      if (w_capture) begin
        r_shadow1 <= digit1;
        r_shadow2 <= digit2;
      end

      // Dropping blink restarts the blink cadence in the visible phase.
      if (!blink) begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b0;
      end else if (w_frame_end) begin
        if (r_blink_cnt == BLK_LAST) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end

      r_an         <= w_an_next;
      r_seg        <= w_seg_next;
      r_frame_tick <= w_frame_end;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_display_mux.sv
module tb_seg7_display_mux;

  localparam int RD = 8;
  localparam int DC = 2;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       blink;
  logic [6:0] digit1;
  logic [6:0] digit2;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;
  logic [6:0] seg_nolz;
  logic [1:0] an_nolz;
  logic       frame_tick_nolz;

  always #5 clk = ~clk;

  seg7_display_mux #(
    .REFRESH_DIV(RD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1), .LZ_BLANK(1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .blink(blink),
    .digit1(digit1), .digit2(digit2),
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  seg7_display_mux #(
    .REFRESH_DIV(RD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1), .LZ_BLANK(0)
  ) u_dut_nolz (
    .clk(clk), .reset_n(reset_n), .enable(enable), .blink(blink),
    .digit1(digit1), .digit2(digit2),
    .seg(seg_nolz), .an(an_nolz), .frame_tick(frame_tick_nolz)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position in the scan is derived from a plain count of
  // enabled cycles since the last restart; blink phase from the number of
  // frames completed while blink stayed high.
  int         m_t;
  int         m_bf;
  logic [6:0] m_sh1;
  logic [6:0] m_sh2;
  logic [1:0] e_an, e_an_nolz;
  logic [6:0] e_seg, e_seg_nolz;
  logic       e_ft;

  task automatic model_reset();
    m_t   = 0;
    m_bf  = 0;
    m_sh1 = '0;
    m_sh2 = '0;
  endtask

  task automatic expect_view(input bit lz, input int c, input int s, input bit ph,
                             output logic [1:0] a, output logic [6:0] sg);
    logic [6:0] pat;
    pat = (s == 1) ? m_sh2 : m_sh1;
    a   = 2'b11;
    sg  = 7'h7F;
    if (c >= DC && !(blink && ph) && !(lz && s == 1 && m_sh2 == 7'b0111111)) begin
      a  = (s == 1) ? 2'b01 : 2'b10;
      sg = ~pat;
    end
  endtask

  // One clock: predict from the inputs currently applied, clock, compare.
  task automatic step();
    int c, s;
    bit ph;
    if (!enable) begin
      e_an = 2'b11; e_an_nolz = 2'b11;
      e_seg = 7'h7F; e_seg_nolz = 7'h7F;
      e_ft = 1'b0;
      m_t = 0;
      m_bf = 0;
    end else begin
      c  = m_t % RD;
      s  = (m_t / RD) % 2;
      ph = ((m_bf / BF) % 2) == 1;
      if (c == 0 && s == 0) begin
        m_sh1 = digit1;
        m_sh2 = digit2;
      end
      expect_view(1'b1, c, s, ph, e_an, e_seg);
      expect_view(1'b0, c, s, ph, e_an_nolz, e_seg_nolz);
      e_ft = (s == 1 && c == RD - 1);
      if (blink) begin
        if (s == 1 && c == RD - 1) m_bf++;
      end else begin
        m_bf = 0;
      end
      m_t++;
    end
    @(posedge clk);
    #1;
    check_eq("an", {6'd0, an}, {6'd0, e_an});
    check_eq("seg", {1'b0, seg}, {1'b0, e_seg});
    check_eq("frame_tick", {7'd0, frame_tick}, {7'd0, e_ft});
    check_eq("an_nolz", {6'd0, an_nolz}, {6'd0, e_an_nolz});
    check_eq("seg_nolz", {1'b0, seg_nolz}, {1'b0, e_seg_nolz});
    check_eq("an_legal", {7'd0, (an == 2'b00)}, 8'd0);
    check_eq("an_nolz_legal", {7'd0, (an_nolz == 2'b00)}, 8'd0);
  endtask

  // Reset asserted between clock edges: outputs must clear with no clock.
  task automatic mid_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_an", {6'd0, an}, 8'h03);
    check_eq("rst_seg", {1'b0, seg}, 8'h7F);
    check_eq("rst_ft", {7'd0, frame_tick}, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_hold_an", {6'd0, an}, 8'h03);
      check_eq("rst_hold_seg", {1'b0, seg}, 8'h7F);
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  // Steps until the ones digit lights; returns how many edges that took.
  task automatic run_to_first_lit(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (an == 2'b10) break;
    end
  endtask

  int n_lit;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    blink   = 1'b0;
    digit1  = 7'b0000110;
    digit2  = 7'b1011011;
    model_reset();
    #12;
    check_eq("reset_an", {6'd0, an}, 8'h03);
    check_eq("reset_seg", {1'b0, seg}, 8'h7F);
    check_eq("reset_ft", {7'd0, frame_tick}, 8'h00);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    enable  = 1'b1;

    // Basic scan: ones lit after DEAD_CYCLES+1 edges, then full frames.
    run_to_first_lit(n_lit);
    check_eq("first_lit", 8'(n_lit), 8'(DC + 1));
    check_eq("ones_seg", {1'b0, seg}, 8'b01111001);
    for (int i = 0; i < 40; i++) step();

    // Mid-frame change of digit2 during the ones slot.
    while ((m_t % (2 * RD)) != 4) step();
    digit2 = 7'b1001111;
    for (int i = 0; i < 40; i++) step();

    // Tens pattern "0": blanked with LZ_BLANK, visible without it.
    digit2 = 7'b0111111;
    for (int i = 0; i < 40; i++) step();
    digit2 = 7'b1011011;

    // Blink: 2 frames lit, 2 dark; release blink while dark.
    blink = 1'b1;
    for (int i = 0; i < 80; i++) step();
    while (!(e_an == 2'b11 && m_t % RD > DC && ((m_bf / BF) % 2) == 1)) step();
    blink = 1'b0;
    for (int i = 0; i < 20; i++) step();

    // Reset while lit.
    while (e_an == 2'b11) step();
    mid_reset();
    run_to_first_lit(n_lit);
    check_eq("first_lit_after_rst", 8'(n_lit), 8'(DC + 1));

    // enable dropped mid tens slot, then restored.
    while ((m_t % (2 * RD)) != RD + 4) step();
    enable = 1'b0;
    step();
    check_eq("dis_an", {6'd0, an}, 8'h03);
    check_eq("dis_seg", {1'b0, seg}, 8'h7F);
    enable = 1'b1;
    run_to_first_lit(n_lit);
    check_eq("first_lit_after_en", 8'(n_lit), 8'(DC + 1));

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        digit1 = 7'($urandom);
        digit2 = ($urandom_range(0, 3) == 0) ? 7'b0111111 : 7'($urandom);
      end
      if ($urandom_range(0, 149) == 0) blink = ~blink;
      if (!enable) enable = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 249) == 0) enable = 1'b0;
      if ($urandom_range(0, 699) == 0 && enable) mid_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case anything above fails to advance.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
